temp_sensor_reader: RTL

Serial acquisition front-end for the room temperature sensor. It runs a 3-wire read-only SPI master frame (cs_n/sclk/sdata) on demand or on a periodic timer, deserializes one sample MSB-first and presents it as a registered parallel word with a one-cycle valid strobe. It is the producer of the temperature word consumed by the AC temperature controller; its output feeds that block's temperature input directly.

---
 rtl/temp_sensor_reader_pkg.sv | 27 ++
 rtl/temp_sensor_reader_tick_gen.sv | 31 +++
 rtl/temp_sensor_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/temp_sensor_reader_pkg.sv
// Shared constants, state encoding and helpers for the temperature sensor reader.
// Sample width comes from `TEMPERATURE_SENSOR_DATA_WIDTH, defaulting to 8 when not provided.

`ifndef TEMPERATURE_SENSOR_DATA_WIDTH
`define TEMPERATURE_SENSOR_DATA_WIDTH 8
`endif

package temp_sensor_reader_pkg;

    localparam int unsigned TEMP_SENSOR_READER_CLK_DIV       = 4;
    localparam int unsigned TEMP_SENSOR_READER_SAMPLE_PERIOD = 1000;
    localparam int unsigned TEMP_SENSOR_READER_DATA_WIDTH    = `TEMPERATURE_SENSOR_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCsSetup = 3'd1,
        StShift   = 3'd2,
        StCsHold  = 3'd3,
        StUpdate  = 3'd4
    } tsr_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned tsr_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temp_sensor_reader_tick_gen.sv
// SCLK half-period timebase: emits a one-cycle tick every CLK_DIV clocks while not cleared.

module temp_sensor_reader_tick_gen
    import temp_sensor_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = TEMP_SENSOR_READER_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = tsr_cnt_width(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick_o = !clear_i && (cnt_q == CntLast);

endmodule

// File: rtl/temp_sensor_reader.sv
// Read-only 3-wire SPI master that fetches one temperature sample per frame, on demand or on a timer.
// Define TEMP_SENSOR_READER_AVG_EN to output the running mean of the last four samples.

module temp_sensor_reader
    import temp_sensor_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV       = TEMP_SENSOR_READER_CLK_DIV,
    parameter int unsigned SAMPLE_PERIOD = TEMP_SENSOR_READER_SAMPLE_PERIOD,
    parameter int unsigned DATA_WIDTH    = TEMP_SENSOR_READER_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  sdata_i,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] temperature_o,
    output logic                  temperature_valid_o
);

    localparam int unsigned BitW   = tsr_cnt_width(DATA_WIDTH);
    localparam int unsigned TimerW = tsr_cnt_width(SAMPLE_PERIOD);
    localparam logic [BitW-1:0]   BitLast   = BitW'(DATA_WIDTH - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_PERIOD - 1);
    localparam logic              AutoEn    = (SAMPLE_PERIOD != 0);

    tsr_state_e            state_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [TimerW-1:0]     timer_q;
    logic                  sclk_q;
    logic                  cs_n_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] temp_q;
    logic                  valid_q;

    logic                  tick;
    logic                  auto_fire;
    logic [DATA_WIDTH-1:0] sample_val;

    temp_sensor_reader_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state_q == StIdle),
        .tick_o  (tick)
    );

    assign auto_fire = AutoEn && (timer_q == TimerLast);

`ifdef TEMP_SENSOR_READER_AVG_EN
    // Three previous raw samples; entry 0 is the most recent.
    logic [DATA_WIDTH-1:0] hist_q [3];
    logic                  primed_q;
    logic [DATA_WIDTH+1:0] avg_sum;
    logic                  load;

    assign load = (state_q == StCsHold) && tick;

    always_comb begin
        avg_sum = {shift_q, 2'b00};
        if (primed_q) begin
            avg_sum = {2'b00, shift_q} + {2'b00, hist_q[0]} +
                      {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        end
        sample_val = avg_sum[DATA_WIDTH+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            primed_q  <= 1'b0;
        end else if (load) begin
            primed_q  <= 1'b1;
            hist_q[0] <= shift_q;
            hist_q[1] <= primed_q ? hist_q[0] : shift_q;
            hist_q[2] <= primed_q ? hist_q[1] : shift_q;
        end
    end
`else
    assign sample_val = shift_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            timer_q   <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            temp_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i || auto_fire) begin
                        state_q   <= StCsSetup;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                    end else if (AutoEn) begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StCsSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        // Sample on the same edge that raises sclk; data was stable during the low phase.
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[DATA_WIDTH-2:0], sdata_i};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == BitLast) begin
                                state_q <= StCsHold;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BitW'(1);
                            end
                        end
                    end
                end
                StCsHold: begin
                    if (tick) begin
                        state_q <= StUpdate;
                        cs_n_q  <= 1'b1;
                        temp_q  <= sample_val;
                        valid_q <= 1'b1;
                    end
                end
                StUpdate: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sclk_o              = sclk_q;
    assign cs_n_o              = cs_n_q;
    assign busy_o              = busy_q;
    assign temperature_o       = temp_q;
    assign temperature_valid_o = valid_q;

endmodule
